vta_mem_responder: RTL and testbench
====================================

# vta_mem_responder

Synthesizable RTL memory responder that services the VTA simulation memory request interface (AR/AW request pulses, write beats, read-data stream with `rd_ready`) entirely in hardware. It takes the place of the host-side DPI memory model when the accelerator shell is simulated or emulated without C co-simulation. It keeps a word-addressed internal array, commits write bursts, and returns read bursts tagged with the request id.

## Interface
- `LEN_BITS`, 8, burst length field width; the burst carries len+1 beats.
- `ADDR_BITS`, 64, byte address width.
- `DATA_BITS`, 64, beat width; must be a multiple of 64.
- `STRB_BITS`, DATA_BITS/8, byte strobes per beat.
- `MEM_WORDS`, 1024, array depth in DATA_BITS words; must be a power of 2.
- `AR_DEPTH`, 2, read-request queue depth; must be a power of 2 and ≥ 2.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_ar_valid`  in  1  one-cycle read request strobe.
- `req_ar_len`  in  LEN_BITS  beats−1.
- `req_ar_id`  in  8  request tag.
- `req_ar_addr`  in  ADDR_BITS  byte address.
- `req_aw_valid`  in  1  one-cycle write request strobe.
- `req_aw_len`  in  LEN_BITS  beats−1.
- `req_aw_addr`  in  ADDR_BITS  byte address.
- `wr_valid`  in  1  write beat strobe.
- `wr_bits_data`  in  DATA_BITS  write beat data.
- `wr_bits_strb`  in  STRB_BITS  byte enables.
- `rd_valid`  out  1  read beat valid.
- `rd_bits_id`  out  8  tag of the current read burst.
- `rd_bits_data`  out  DATA_BITS  read beat data.
- `rd_ready`  in  1  consumer accepts the beat.
- `wr_done`  out  1  one-cycle pulse after the last write beat commits.
- `err`  out  3  sticky flags: [0] AR queue overflow, [1] orphan write beat, [2] AW received while a write is active.

## Operation
- Word index = addr[log2(MEM_WORDS)+log2(STRB_BITS)−1 : log2(STRB_BITS)]. Low byte bits are ignored. Beat k uses (index+k) mod MEM_WORDS, so bursts wrap at the top of the array.
- The request inputs have no ready signal, so every request must be absorbed:
  - AR requests are pushed into an AR_DEPTH FIFO holding {id, len, index}.
  - A push while the FIFO is full drops the request and sets err[0].
- Read FSM:
  - RD_IDLE: when the FIFO is not empty, pop the head, load the beat counter with len and the index register, and go to RD_BEAT.
  - RD_BEAT: rd_valid=1, with data and id registered. On rd_valid&rd_ready: if the counter is 0, return to RD_IDLE; otherwise decrement the counter, increment the index, and load the next word in the same cycle, keeping rd_valid high with no bubble.
  - rd_bits_data and rd_bits_id are held stable while rd_valid&!rd_ready.
- Write FSM:
  - WR_IDLE: on req_aw_valid, capture len and index and go to WR_DATA.
  - WR_DATA: each wr_valid commits the bytes with strb=1 to mem[index] at the clock edge, then the index increments. After len+1 beats, pulse wr_done for one cycle and return to WR_IDLE.
  - wr_valid in WR_IDLE is ignored and sets err[1].
  - req_aw_valid in WR_DATA is ignored and sets err[2].
  - A wr_valid arriving in the same cycle as the AW strobe that opens the burst is treated as orphaned.
- Read/write same word, same cycle: the read loads the pre-write contents. Reads observe writes committed on earlier edges.
- Reads and writes proceed concurrently and independently.

## Timing
- Reset values: rd_valid=0, rd_bits_id=0, rd_bits_data=0, wr_done=0, err=0; both FSMs idle; FIFO empty. Memory contents are not cleared.
- Reset asserted mid-burst aborts both bursts immediately and discards queued reads.
- Read latency: with an empty FIFO and RD_IDLE, req_ar_valid at edge t gives the first rd_valid at edge t+2. Subsequent beats follow at one beat per accepted handshake.
- Back-to-back bursts incur one RD_IDLE cycle between the last beat of one burst and the first beat of the next.
- Write: a beat sampled at edge t is visible to a read load at edge t+1 or later. wr_done is high in the cycle after the last beat's edge.
- FIFO push and pop in the same cycle while full: the pop frees a slot first, so the push is accepted.

## Test plan
- Write then read: write 4 beats (aw_len=3, addr 0x40, data 1..4, strb all ones), then read with ar_len=3, id 0x5A, addr 0x40. Required: wr_done pulses once; the read returns 1,2,3,4 with id 0x5A on four consecutive cycles while rd_ready=1.
- Strobes: preload word 0 with 0xFFFF_FFFF_FFFF_FFFF, write 0x1122334455667788 with strb 0x0F, then read. Required: 0xFFFF_FFFF_5566_7788.
- Backpressure: drive rd_ready in a 1,0,0,1 pattern during a 3-beat read. Required: data and id are held during stalls; exactly 3 beats are accepted, in order, with none duplicated.
- Queue overflow and wrap, with AR_DEPTH=2 and MEM_WORDS=1024:
  - Issue 4 AR strobes on consecutive cycles, with ids 1..4 and len 0. Required: ids 1 and 2 plus exactly one of ids 3 and 4 are returned, and err[0]=1.
  - Issue a read at index 1023 with len 1. Required: words 1023 then 0.
- Errors and reset:
  - Drive wr_valid with no AW. Required: err[1]=1 and memory unchanged.
  - Assert reset in the middle of a 4-beat read. Required: rd_valid=0 with no clock edge; after release, memory retains its data and err=0.

Source files
------------

// File: rtl/vta_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : vta_mem_responder_if
// Brief    : VTA simulation memory request/response bundle (AR/AW/W/R).
// Revision : 1.0
// ============================================================================
interface vta_mem_responder_if #(
  parameter int LEN_BITS  = 8,
  parameter int ADDR_BITS = 64,
  parameter int DATA_BITS = 64,
  parameter int STRB_BITS = DATA_BITS / 8
) ();
  logic                 req_ar_valid;
  logic [LEN_BITS-1:0]  req_ar_len;
  logic [7:0]           req_ar_id;
  logic [ADDR_BITS-1:0] req_ar_addr;
  logic                 req_aw_valid;
  logic [LEN_BITS-1:0]  req_aw_len;
  logic [ADDR_BITS-1:0] req_aw_addr;
  logic                 wr_valid;
  logic [DATA_BITS-1:0] wr_bits_data;
  logic [STRB_BITS-1:0] wr_bits_strb;
  logic                 rd_valid;
  logic [7:0]           rd_bits_id;
  logic [DATA_BITS-1:0] rd_bits_data;
  logic                 rd_ready;
  logic                 wr_done;
  logic [2:0]           err;

  modport master (
    output req_ar_valid, req_ar_len, req_ar_id, req_ar_addr,
    output req_aw_valid, req_aw_len, req_aw_addr,
    output wr_valid, wr_bits_data, wr_bits_strb, rd_ready,
    input  rd_valid, rd_bits_id, rd_bits_data, wr_done, err
  );

  modport slave (
    input  req_ar_valid, req_ar_len, req_ar_id, req_ar_addr,
    input  req_aw_valid, req_aw_len, req_aw_addr,
    input  wr_valid, wr_bits_data, wr_bits_strb, rd_ready,
    output rd_valid, rd_bits_id, rd_bits_data, wr_done, err
  );
endinterface
`default_nettype wire

// File: rtl/vta_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : vta_mem_responder
// Brief    : Hardware VTA memory model: queued read bursts, write bursts.
// Revision : 1.0
// ============================================================================
module vta_mem_responder #(
  parameter int LEN_BITS  = 8,
  parameter int ADDR_BITS = 64,
  parameter int DATA_BITS = 64,
  parameter int STRB_BITS = DATA_BITS / 8,
  parameter int MEM_WORDS = 1024,
  parameter int AR_DEPTH  = 2
) (
  input  wire logic          clock,
  input  wire logic          reset,
  vta_mem_responder_if.slave bus
);
  localparam int c_BYTE_W = $clog2(STRB_BITS);
  localparam int c_IDX_W  = $clog2(MEM_WORDS);
  localparam int c_PTR_W  = $clog2(AR_DEPTH);

  typedef enum logic [0:0] {RD_IDLE = 1'b0, RD_BEAT = 1'b1} rd_state_t;
  typedef enum logic [0:0] {WR_IDLE = 1'b0, WR_DATA = 1'b1} wr_state_t;

  logic [DATA_BITS-1:0] r_mem [MEM_WORDS];

  logic [c_IDX_W-1:0] w_ar_idx;
  logic [c_IDX_W-1:0] w_aw_idx;
  logic               w_unused_addr;
  assign w_ar_idx = bus.req_ar_addr[c_IDX_W+c_BYTE_W-1:c_BYTE_W];
  assign w_aw_idx = bus.req_aw_addr[c_IDX_W+c_BYTE_W-1:c_BYTE_W];
  assign w_unused_addr = ^{bus.req_ar_addr[ADDR_BITS-1:c_IDX_W+c_BYTE_W], bus.req_ar_addr[c_BYTE_W-1:0],
                           bus.req_aw_addr[ADDR_BITS-1:c_IDX_W+c_BYTE_W], bus.req_aw_addr[c_BYTE_W-1:0]};

  // AR queue: one extra pointer bit distinguishes full from empty
  logic [7:0]          r_q_id  [AR_DEPTH];
  logic [LEN_BITS-1:0] r_q_len [AR_DEPTH];
  logic [c_IDX_W-1:0]  r_q_idx [AR_DEPTH];
  logic [c_PTR_W:0]    r_q_wptr;
  logic [c_PTR_W:0]    r_q_rptr;
  logic                w_q_empty;
  logic                w_q_full;
  logic                w_q_push;
  logic                w_q_pop;

  assign w_q_empty = (r_q_wptr == r_q_rptr);
  assign w_q_full  = (r_q_wptr[c_PTR_W] != r_q_rptr[c_PTR_W]) &&
                     (r_q_wptr[c_PTR_W-1:0] == r_q_rptr[c_PTR_W-1:0]);
  assign w_q_push  = bus.req_ar_valid && (!w_q_full || w_q_pop);

  always_ff @(posedge clock) begin
    if (w_q_push) begin
      r_q_id[r_q_wptr[c_PTR_W-1:0]]  <= bus.req_ar_id;
      r_q_len[r_q_wptr[c_PTR_W-1:0]] <= bus.req_ar_len;
      r_q_idx[r_q_wptr[c_PTR_W-1:0]] <= w_ar_idx;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q_wptr <= '0;
      r_q_rptr <= '0;
    end else begin
      if (w_q_push) r_q_wptr <= r_q_wptr + (c_PTR_W+1)'(1);
      if (w_q_pop)  r_q_rptr <= r_q_rptr + (c_PTR_W+1)'(1);
    end
  end

  // Read FSM
  rd_state_t           r_rd_state;
  rd_state_t           w_rd_next;
  logic                w_rd_adv;
  logic [LEN_BITS-1:0] r_rd_cnt;
  logic [c_IDX_W-1:0]  r_rd_idx;
  logic [7:0]          r_rd_id;
  logic [DATA_BITS-1:0] r_rd_data;
  logic [c_IDX_W-1:0]  w_rd_fetch_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_rd_state <= RD_IDLE;
    else       r_rd_state <= w_rd_next;
  end

  always_comb begin
    w_rd_next = r_rd_state;
    w_q_pop   = 1'b0;
    w_rd_adv  = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        if (!w_q_empty) begin
          w_q_pop   = 1'b1;
          w_rd_next = RD_BEAT;
        end
      end
      RD_BEAT: begin
        if (bus.rd_ready) begin
          if (r_rd_cnt == '0) w_rd_next = RD_IDLE;
          else                w_rd_adv  = 1'b1;
        end
      end
      default: w_rd_next = RD_IDLE;
    endcase
  end

  assign w_rd_fetch_idx = w_q_pop ? r_q_idx[r_q_rptr[c_PTR_W-1:0]] : r_rd_idx + c_IDX_W'(1);

  // Loads sample the array before this edge's write, giving read-before-write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_cnt  <= '0;
      r_rd_idx  <= '0;
      r_rd_id   <= '0;
      r_rd_data <= '0;
    end else if (w_q_pop) begin
      r_rd_cnt  <= r_q_len[r_q_rptr[c_PTR_W-1:0]];
      r_rd_idx  <= w_rd_fetch_idx;
      r_rd_id   <= r_q_id[r_q_rptr[c_PTR_W-1:0]];
      r_rd_data <= r_mem[w_rd_fetch_idx];
    end else if (w_rd_adv) begin
      r_rd_cnt  <= r_rd_cnt - LEN_BITS'(1);
      r_rd_idx  <= w_rd_fetch_idx;
      r_rd_data <= r_mem[w_rd_fetch_idx];
    end
  end

  // Write FSM
  wr_state_t           r_wr_state;
  wr_state_t           w_wr_next;
  logic                w_mem_we;
  logic                w_wr_last;
  logic [LEN_BITS-1:0] r_wr_cnt;
  logic [c_IDX_W-1:0]  r_wr_idx;
  logic                r_wr_done;
  logic [2:0]          r_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_wr_state <= WR_IDLE;
    else       r_wr_state <= w_wr_next;
  end

  always_comb begin
    w_wr_next = r_wr_state;
    w_mem_we  = 1'b0;
    w_wr_last = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        if (bus.req_aw_valid) w_wr_next = WR_DATA;
      end
      WR_DATA: begin
        if (bus.wr_valid) begin
          w_mem_we = 1'b1;
          if (r_wr_cnt == '0) begin
            w_wr_last = 1'b1;
            w_wr_next = WR_IDLE;
          end
        end
      end
      default: w_wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_cnt  <= '0;
      r_wr_idx  <= '0;
      r_wr_done <= 1'b0;
      r_err     <= '0;
    end else begin
      r_wr_done <= w_wr_last;
      r_err     <= r_err | {(r_wr_state == WR_DATA) && bus.req_aw_valid,
                            (r_wr_state == WR_IDLE) && bus.wr_valid,
                            bus.req_ar_valid && w_q_full && !w_q_pop};
      if ((r_wr_state == WR_IDLE) && bus.req_aw_valid) begin
        r_wr_cnt <= bus.req_aw_len;
        r_wr_idx <= w_aw_idx;
      end else if (w_mem_we) begin
        r_wr_cnt <= r_wr_cnt - LEN_BITS'(1);
        r_wr_idx <= r_wr_idx + c_IDX_W'(1);
      end
    end
  end

  // Array contents deliberately survive reset
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      for (int b = 0; b < STRB_BITS; b++) begin
        if (bus.wr_bits_strb[b]) r_mem[r_wr_idx][b*8 +: 8] <= bus.wr_bits_data[b*8 +: 8];
      end
    end
  end

  assign bus.rd_valid     = (r_rd_state == RD_BEAT);
  assign bus.rd_bits_id   = r_rd_id;
  assign bus.rd_bits_data = r_rd_data;
  assign bus.wr_done      = r_wr_done;
  assign bus.err          = r_err;
endmodule
`default_nettype wire

// File: tb/tb_vta_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_vta_mem_responder
// Brief    : Self-checking bench for vta_mem_responder against a word-array model.
// Revision : 1.0
// ============================================================================
module tb_vta_mem_responder;
  localparam int c_WORDS = 1024;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  vta_mem_responder_if #(.LEN_BITS(8), .ADDR_BITS(64), .DATA_BITS(64), .STRB_BITS(8)) bus ();

  vta_mem_responder #(
    .LEN_BITS(8), .ADDR_BITS(64), .DATA_BITS(64), .STRB_BITS(8), .MEM_WORDS(c_WORDS), .AR_DEPTH(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] model_mem [c_WORDS];
  logic [63:0] wdata_q [$];
  logic [7:0]  wstrb_q [$];
  logic [63:0] rx_data [$];
  logic [7:0]  rx_id   [$];

  function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w, input logic [7:0] strb);
    logic [63:0] m;
    m = old_w;
    for (int b = 0; b < 8; b++) if (strb[b]) m[b*8 +: 8] = new_w[b*8 +: 8];
    return m;
  endfunction

  function automatic int word_of(input logic [63:0] addr);
    return int'((addr / 64'd8) % 64'(c_WORDS));
  endfunction

  // All tasks start and end just after a falling edge
  task automatic do_write(input logic [63:0] addr, input int nbeats, input bit gaps,
                          output int done_cnt, output bit done_ok);
    int wi;
    wi = word_of(addr);
    done_cnt = 0;
    done_ok  = 1'b0;
    bus.req_aw_valid = 1'b1;
    bus.req_aw_len   = 8'(nbeats - 1);
    bus.req_aw_addr  = addr;
    @(negedge clock);
    bus.req_aw_valid = 1'b0;
    for (int k = 0; k < nbeats; k++) begin
      if (gaps) begin
        while ($urandom_range(3) == 0) begin
          bus.wr_valid = 1'b0;
          @(negedge clock);
          if (bus.wr_done) done_cnt++;
        end
      end
      bus.wr_valid     = 1'b1;
      bus.wr_bits_data = wdata_q[k];
      bus.wr_bits_strb = wstrb_q[k];
      model_mem[(wi + k) % c_WORDS] = merge(model_mem[(wi + k) % c_WORDS], wdata_q[k], wstrb_q[k]);
      @(negedge clock);
      if (bus.wr_done) done_cnt++;
      if (k == nbeats - 1) done_ok = bus.wr_done;
    end
    bus.wr_valid = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (bus.wr_done) done_cnt++;
    end
  endtask

  task automatic issue_ar(input logic [63:0] addr, input logic [7:0] len, input logic [7:0] id);
    bus.req_ar_valid = 1'b1;
    bus.req_ar_addr  = addr;
    bus.req_ar_len   = len;
    bus.req_ar_id    = id;
    @(negedge clock);
    bus.req_ar_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: 1,0,0,1 per valid cycle, 2: random
  task automatic collect(input int n, input int mode, output int hold_errs, output int timeouts, output int bubbles);
    int          cyc;
    int          phase;
    bit          stall;
    bit          got;
    bit          r;
    logic [63:0] hd;
    logic [7:0]  hid;
    cyc = 0; phase = 0; stall = 1'b0; got = 1'b0; hd = '0; hid = '0;
    hold_errs = 0; timeouts = 0; bubbles = 0;
    rx_data.delete();
    rx_id.delete();
    while (rx_data.size() < n) begin
      if (cyc > 100 + 8 * n) begin
        timeouts = 1;
        break;
      end
      if (mode == 0)      r = 1'b1;
      else if (mode == 1) r = (phase % 4 == 0) || (phase % 4 == 3);
      else                r = 1'($urandom_range(1));
      if (stall && (!bus.rd_valid || bus.rd_bits_data !== hd || bus.rd_bits_id !== hid)) hold_errs++;
      if (got && !bus.rd_valid) bubbles++;
      bus.rd_ready = r;
      if (bus.rd_valid && r) begin
        rx_data.push_back(bus.rd_bits_data);
        rx_id.push_back(bus.rd_bits_id);
        got = 1'b1;
      end
      stall = bus.rd_valid && !r;
      hd    = bus.rd_bits_data;
      hid   = bus.rd_bits_id;
      if (bus.rd_valid) phase++;
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic count_extra(input int cycles, output int extra);
    extra = 0;
    bus.rd_ready = 1'b1;
    repeat (cycles) begin
      if (bus.rd_valid) extra++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got %b expected 0", bus.rd_valid); end
    checks++; if (bus.rd_bits_id !== 8'h00) begin failures++; $display("FAIL reset_rd_id got %h expected 00", bus.rd_bits_id); end
    checks++; if (bus.rd_bits_data !== 64'h0) begin failures++; $display("FAIL reset_rd_data got %h expected 0", bus.rd_bits_data); end
    checks++; if (bus.wr_done !== 1'b0) begin failures++; $display("FAIL reset_wr_done got %b expected 0", bus.wr_done); end
    checks++; if (bus.err !== 3'b000) begin failures++; $display("FAIL reset_err got %b expected 000", bus.err); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_init();
    int dc;
    bit dk;
    for (int c = 0; c < 4; c++) begin
      wdata_q.delete(); wstrb_q.delete();
      for (int k = 0; k < 256; k++) begin
        wdata_q.push_back({$urandom, $urandom});
        wstrb_q.push_back(8'hFF);
      end
      do_write(64'(c * 256 * 8), 256, 1'b0, dc, dk);
      checks++; if (dc != 1 || !dk) begin failures++; $display("FAIL init_wr_done chunk %0d got pulses=%0d on_time=%0d expected 1/1", c, dc, dk); end
    end
  endtask

  task automatic test_write_read();
    int dc, he, to, bu;
    bit dk;
    wdata_q.delete(); wstrb_q.delete();
    for (int k = 0; k < 4; k++) begin
      wdata_q.push_back(64'(k + 1));
      wstrb_q.push_back(8'hFF);
    end
    do_write(64'h40, 4, 1'b0, dc, dk);
    checks++; if (dc != 1 || !dk) begin failures++; $display("FAIL wr_done_pulse got pulses=%0d on_time=%0d expected 1/1", dc, dk); end
    issue_ar(64'h40, 8'd3, 8'h5A);
    collect(4, 0, he, to, bu);
    checks++; if (to != 0 || rx_data.size() != 4) begin failures++; $display("FAIL wr_rd_count got %0d beats expected 4", rx_data.size()); end
    for (int k = 0; k < rx_data.size(); k++) begin
      checks++;
      if (rx_data[k] !== 64'(k + 1) || rx_id[k] !== 8'h5A) begin
        failures++; $display("FAIL wr_rd_beat%0d got %h/%h expected %h/5a", k, rx_data[k], rx_id[k], 64'(k + 1));
      end
    end
    checks++; if (bu != 0) begin failures++; $display("FAIL wr_rd_consecutive got %0d bubbles expected 0", bu); end
  endtask

  task automatic test_strobe();
    int dc, he, to, bu;
    bit dk;
    wdata_q.delete(); wstrb_q.delete();
    wdata_q.push_back(64'hFFFF_FFFF_FFFF_FFFF); wstrb_q.push_back(8'hFF);
    do_write(64'h0, 1, 1'b0, dc, dk);
    wdata_q.delete(); wstrb_q.delete();
    wdata_q.push_back(64'h1122_3344_5566_7788); wstrb_q.push_back(8'h0F);
    do_write(64'h0, 1, 1'b0, dc, dk);
    issue_ar(64'h0, 8'd0, 8'h11);
    collect(1, 0, he, to, bu);
    checks++;
    if (to != 0 || rx_data.size() != 1 || rx_data[0] !== 64'hFFFF_FFFF_5566_7788) begin
      failures++; $display("FAIL strobe got %h (beats=%0d) expected ffffffff55667788", (rx_data.size() > 0) ? rx_data[0] : 64'hx, rx_data.size());
    end
  endtask

  task automatic test_backpressure();
    int he, to, bu, ex;
    issue_ar(64'(50 * 8), 8'd2, 8'h3C);
    collect(3, 1, he, to, bu);
    count_extra(6, ex);
    checks++; if (he != 0) begin failures++; $display("FAIL bp_hold got %0d hold violations expected 0", he); end
    checks++; if (to != 0 || rx_data.size() != 3 || ex != 0) begin failures++; $display("FAIL bp_count got %0d+%0d beats expected 3+0", rx_data.size(), ex); end
    for (int k = 0; k < rx_data.size(); k++) begin
      checks++;
      if (rx_data[k] !== model_mem[50 + k] || rx_id[k] !== 8'h3C) begin
        failures++; $display("FAIL bp_beat%0d got %h/%h expected %h/3c", k, rx_data[k], rx_id[k], model_mem[50 + k]);
      end
    end
  endtask

  task automatic test_latency_back_to_back();
    logic [5:0]  seq;
    logic [63:0] got_q [$];
    logic [63:0] exp_d [4];
    bus.rd_ready     = 1'b1;
    bus.req_ar_valid = 1'b1;
    bus.req_ar_addr  = 64'(60 * 8);
    bus.req_ar_len   = 8'd0;
    bus.req_ar_id    = 8'h33;
    @(negedge clock);
    bus.req_ar_valid = 1'b0;
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL latency_early got rd_valid=%b expected 0", bus.rd_valid); end
    @(negedge clock);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_bits_data !== model_mem[60] || bus.rd_bits_id !== 8'h33) begin
      failures++; $display("FAIL latency_first got v=%b %h/%h expected 1 %h/33", bus.rd_valid, bus.rd_bits_data, bus.rd_bits_id, model_mem[60]);
    end
    @(negedge clock);
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL latency_end got rd_valid=%b expected 0", bus.rd_valid); end
    issue_ar(64'(70 * 8), 8'd1, 8'hA1);
    issue_ar(64'(80 * 8), 8'd1, 8'hB2);
    seq = '0;
    for (int i = 0; i < 6; i++) begin
      seq[5 - i] = bus.rd_valid;
      if (bus.rd_valid) got_q.push_back(bus.rd_bits_data);
      @(negedge clock);
    end
    checks++; if (seq !== 6'b110110) begin failures++; $display("FAIL b2b_gap got %b expected 110110", seq); end
    exp_d[0] = model_mem[70]; exp_d[1] = model_mem[71]; exp_d[2] = model_mem[80]; exp_d[3] = model_mem[81];
    checks++;
    if (got_q.size() != 4) begin
      failures++; $display("FAIL b2b_count got %0d expected 4", got_q.size());
    end else if (got_q[0] !== exp_d[0] || got_q[1] !== exp_d[1] || got_q[2] !== exp_d[2] || got_q[3] !== exp_d[3]) begin
      failures++; $display("FAIL b2b_data got %h %h %h %h expected %h %h %h %h", got_q[0], got_q[1], got_q[2], got_q[3], exp_d[0], exp_d[1], exp_d[2], exp_d[3]);
    end
  endtask

  task automatic test_overflow();
    int he, to, bu, ex, n34;
    checks++; if (bus.err !== 3'b000) begin failures++; $display("FAIL ovf_pre_err got %b expected 000", bus.err); end
    bus.rd_ready = 1'b0;
    for (int i = 1; i <= 4; i++) issue_ar(64'((90 + i) * 8), 8'd0, 8'(i));
    collect(3, 0, he, to, bu);
    count_extra(8, ex);
    checks++; if (to != 0 || rx_data.size() != 3 || ex != 0) begin failures++; $display("FAIL ovf_count got %0d+%0d beats expected 3+0", rx_data.size(), ex); end
    if (rx_id.size() == 3) begin
      n34 = ((rx_id[2] == 8'd3) || (rx_id[2] == 8'd4)) ? 1 : 0;
      checks++;
      if (rx_id[0] !== 8'd1 || rx_id[1] !== 8'd2 || n34 != 1) begin
        failures++; $display("FAIL ovf_ids got %0d,%0d,%0d expected 1,2,(3|4)", rx_id[0], rx_id[1], rx_id[2]);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rx_data[k] !== model_mem[(90 + int'(rx_id[k])) % c_WORDS]) begin
          failures++; $display("FAIL ovf_data%0d got %h expected %h", k, rx_data[k], model_mem[(90 + int'(rx_id[k])) % c_WORDS]);
        end
      end
    end
    checks++; if (bus.err[0] !== 1'b1) begin failures++; $display("FAIL ovf_err0 got %b expected 1", bus.err[0]); end
  endtask

  task automatic test_wrap();
    int he, to, bu;
    logic [63:0] a;
    logic [7:0]  id;
    a = {$urandom, $urandom};
    a[12:3] = 10'd1023;
    id = 8'($urandom);
    issue_ar(a, 8'd1, id);
    collect(2, 2, he, to, bu);
    checks++;
    if (to != 0 || rx_data.size() != 2) begin
      failures++; $display("FAIL wrap_count got %0d expected 2", rx_data.size());
    end else if (rx_data[0] !== model_mem[1023] || rx_data[1] !== model_mem[0] || rx_id[0] !== id || rx_id[1] !== id) begin
      failures++; $display("FAIL wrap_data got %h %h expected %h %h", rx_data[0], rx_data[1], model_mem[1023], model_mem[0]);
    end
  endtask

  task automatic test_orphan();
    int dc, he, to, bu;
    bit dk;
    wdata_q.delete(); wstrb_q.delete();
    wdata_q.push_back({$urandom, $urandom}); wstrb_q.push_back(8'hFF);
    do_write(64'(5 * 8), 1, 1'b0, dc, dk);
    bus.wr_valid     = 1'b1;
    bus.wr_bits_data = ~model_mem[5];
    bus.wr_bits_strb = 8'hFF;
    @(negedge clock);
    bus.wr_valid = 1'b0;
    @(negedge clock);
    checks++; if (bus.err[1] !== 1'b1) begin failures++; $display("FAIL orphan_err1 got %b expected 1", bus.err[1]); end
    issue_ar(64'(5 * 8), 8'd1, 8'h05);
    collect(2, 0, he, to, bu);
    checks++;
    if (to != 0 || rx_data.size() != 2 || rx_data[0] !== model_mem[5] || rx_data[1] !== model_mem[6]) begin
      failures++; $display("FAIL orphan_mem got %0d beats first %h expected %h %h", rx_data.size(), (rx_data.size() > 0) ? rx_data[0] : 64'hx, model_mem[5], model_mem[6]);
    end
  endtask

  task automatic test_aw_busy();
    int he, to, bu;
    logic [63:0] d0, d1;
    d0 = {$urandom, $urandom};
    d1 = {$urandom, $urandom};
    bus.req_aw_valid = 1'b1; bus.req_aw_len = 8'd1; bus.req_aw_addr = 64'(300 * 8);
    @(negedge clock);
    bus.req_aw_addr = 64'(400 * 8); bus.req_aw_len = 8'd0;
    bus.wr_valid = 1'b1; bus.wr_bits_data = d0; bus.wr_bits_strb = 8'hFF;
    model_mem[300] = d0;
    @(negedge clock);
    bus.req_aw_valid = 1'b0;
    bus.wr_bits_data = d1;
    model_mem[301] = d1;
    @(negedge clock);
    bus.wr_valid = 1'b0;
    checks++; if (bus.wr_done !== 1'b1) begin failures++; $display("FAIL awbusy_done got %b expected 1", bus.wr_done); end
    checks++; if (bus.err[2] !== 1'b1) begin failures++; $display("FAIL awbusy_err2 got %b expected 1", bus.err[2]); end
    @(negedge clock);
    issue_ar(64'(300 * 8), 8'd1, 8'h30);
    collect(2, 0, he, to, bu);
    checks++;
    if (to != 0 || rx_data.size() != 2 || rx_data[0] !== d0 || rx_data[1] !== d1) begin
      failures++; $display("FAIL awbusy_data got %0d beats expected %h %h", rx_data.size(), d0, d1);
    end
  endtask

  task automatic test_random();
    int dc, he, to, bu, nb, wi, ln, bad;
    bit dk;
    logic [63:0] a;
    logic [7:0]  id;
    for (int it = 0; it < 20; it++) begin
      nb = int'($urandom_range(1, 8));
      wdata_q.delete(); wstrb_q.delete();
      for (int k = 0; k < nb; k++) begin
        wdata_q.push_back({$urandom, $urandom});
        wstrb_q.push_back(8'($urandom));
      end
      do_write({$urandom, $urandom}, nb, 1'b1, dc, dk);
      checks++; if (dc != 1 || !dk) begin failures++; $display("FAIL rand_wr_done it%0d got %0d/%0d expected 1/1", it, dc, dk); end
      a  = {$urandom, $urandom};
      wi = word_of(a);
      ln = int'($urandom_range(0, 15));
      id = 8'($urandom);
      issue_ar(a, 8'(ln), id);
      collect(ln + 1, 2, he, to, bu);
      bad = 0;
      for (int k = 0; k < rx_data.size(); k++)
        if (rx_data[k] !== model_mem[(wi + k) % c_WORDS] || rx_id[k] !== id) bad++;
      checks++;
      if (to != 0 || he != 0 || bad != 0 || rx_data.size() != ln + 1) begin
        failures++; $display("FAIL rand_rd it%0d got beats=%0d bad=%0d hold=%0d expected beats=%0d bad=0 hold=0", it, rx_data.size(), bad, he, ln + 1);
      end
    end
  endtask

  task automatic test_concurrent();
    int dc, he, to, bu, bad;
    bit dk;
    logic [63:0] exp_d [8];
    for (int k = 0; k < 8; k++) exp_d[k] = model_mem[200 + k];
    wdata_q.delete(); wstrb_q.delete();
    for (int k = 0; k < 8; k++) begin
      wdata_q.push_back({$urandom, $urandom});
      wstrb_q.push_back(8'hFF);
    end
    fork
      do_write(64'(100 * 8), 8, 1'b1, dc, dk);
      begin
        issue_ar(64'(200 * 8), 8'd7, 8'h77);
        collect(8, 2, he, to, bu);
      end
    join
    bad = 0;
    for (int k = 0; k < rx_data.size(); k++) if (rx_data[k] !== exp_d[k]) bad++;
    checks++;
    if (to != 0 || bad != 0 || rx_data.size() != 8 || dc != 1) begin
      failures++; $display("FAIL concurrent got beats=%0d bad=%0d done=%0d expected 8/0/1", rx_data.size(), bad, dc);
    end
  endtask

  task automatic test_midreset();
    int he, to, bu, ex;
    bus.rd_ready = 1'b0;
    issue_ar(64'(20 * 8), 8'd3, 8'h21);
    issue_ar(64'(30 * 8), 8'd0, 8'h22);
    issue_ar(64'(40 * 8), 8'd0, 8'h23);
    checks++; if (bus.rd_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre got rd_valid=%b expected 1", bus.rd_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL midrst_async got rd_valid=%b expected 0", bus.rd_valid); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    count_extra(8, ex);
    checks++; if (ex != 0) begin failures++; $display("FAIL midrst_queue got %0d beats expected 0", ex); end
    checks++; if (bus.err !== 3'b000) begin failures++; $display("FAIL midrst_err got %b expected 000", bus.err); end
    issue_ar(64'(20 * 8), 8'd3, 8'h24);
    collect(4, 0, he, to, bu);
    checks++;
    if (to != 0 || rx_data.size() != 4 || rx_data[0] !== model_mem[20] || rx_data[3] !== model_mem[23]) begin
      failures++; $display("FAIL midrst_mem got %0d beats expected %h..%h", rx_data.size(), model_mem[20], model_mem[23]);
    end
  endtask

  initial begin
    bus.req_ar_valid = 1'b0; bus.req_ar_len = '0; bus.req_ar_id = '0; bus.req_ar_addr = '0;
    bus.req_aw_valid = 1'b0; bus.req_aw_len = '0; bus.req_aw_addr = '0;
    bus.wr_valid = 1'b0; bus.wr_bits_data = '0; bus.wr_bits_strb = '0;
    bus.rd_ready = 1'b0;
    test_reset();
    test_init();
    test_write_read();
    test_strobe();
    test_backpressure();
    test_latency_back_to_back();
    test_overflow();
    test_wrap();
    test_orphan();
    test_aw_busy();
    test_random();
    test_concurrent();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
